// File: rtl/init_command_sequencer.sv
// Initialisation and operation command sequencer for an 8259-style interrupt controller.
// Decodes bus write events into ICW1..ICW4 configuration and OCW1..OCW3 runtime controls.
module init_command_sequencer (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       write_enable,
  input  logic       A0,
  input  logic [7:0] internal_bus,
  output logic       init_done,
  output logic       edge_level,
  output logic       single_mode,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_config,
  output logic       aeoi,
  output logic [1:0] buffered_mode,
  output logic       sfnm,
  output logic       upm,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [5:0] ocw2_cmd,
  output logic       rotate_aeoi,
  output logic       read_isr,
  output logic       special_mask,
  output logic       poll_req
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitIcw2,
    StWaitIcw3,
    StWaitIcw4,
    StReady
  } state_e;

  state_e     state_q, state_d;
  logic       we_q;
  logic       ic4_q, ic4_d;
  logic       edge_level_q, edge_level_d;
  logic       single_mode_q, single_mode_d;
  logic [4:0] vector_base_q, vector_base_d;
  logic [7:0] cascade_config_q, cascade_config_d;
  logic       aeoi_q, aeoi_d;
  logic [1:0] buffered_mode_q, buffered_mode_d;
  logic       sfnm_q, sfnm_d;
  logic       upm_q, upm_d;
  logic [7:0] imr_q, imr_d;
  logic       ocw2_valid_q, ocw2_valid_d;
  logic [5:0] ocw2_cmd_q, ocw2_cmd_d;
  logic       rotate_aeoi_q, rotate_aeoi_d;
  logic       read_isr_q, read_isr_d;
  logic       special_mask_q, special_mask_d;
  logic       poll_req_q, poll_req_d;

  // A held write level yields a single event on its rising edge only.
  logic wr_event;
  logic is_icw1, is_ocw2, is_ocw3, is_data;

  always_comb begin
    wr_event = write_enable & ~we_q;
    is_icw1  = wr_event & ~A0 & internal_bus[4];
    is_ocw2  = wr_event & ~A0 & ~internal_bus[4] & ~internal_bus[3];
    is_ocw3  = wr_event & ~A0 & ~internal_bus[4] & internal_bus[3];
    is_data  = wr_event & A0;
  end

  always_comb begin
    state_d          = state_q;
    ic4_d            = ic4_q;
    edge_level_d     = edge_level_q;
    single_mode_d    = single_mode_q;
    vector_base_d    = vector_base_q;
    cascade_config_d = cascade_config_q;
    aeoi_d           = aeoi_q;
    buffered_mode_d  = buffered_mode_q;
    sfnm_d           = sfnm_q;
    upm_d            = upm_q;
    imr_d            = imr_q;
    ocw2_valid_d     = 1'b0;
    ocw2_cmd_d       = ocw2_cmd_q;
    rotate_aeoi_d    = rotate_aeoi_q;
    read_isr_d       = read_isr_q;
    special_mask_d   = special_mask_q;
    poll_req_d       = 1'b0;

    if (is_icw1) begin
      // ICW1 restarts initialisation from any state.
      state_d        = StWaitIcw2;
      edge_level_d   = internal_bus[3];
      single_mode_d  = internal_bus[1];
      ic4_d          = internal_bus[0];
      imr_d          = 8'h00;
      special_mask_d = 1'b0;
      read_isr_d     = 1'b0;
      rotate_aeoi_d  = 1'b0;
      if (!internal_bus[0]) begin
        aeoi_d          = 1'b0;
        buffered_mode_d = 2'b00;
        sfnm_d          = 1'b0;
        upm_d           = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StWaitIcw2: begin
          if (is_data) begin
            vector_base_d = internal_bus[7:3];
            if (!single_mode_q) begin
              state_d = StWaitIcw3;
            end else if (ic4_q) begin
              state_d = StWaitIcw4;
            end else begin
              state_d = StReady;
            end
          end
        end
        StWaitIcw3: begin
          if (is_data) begin
            cascade_config_d = internal_bus;
            state_d          = ic4_q ? StWaitIcw4 : StReady;
          end
        end
        StWaitIcw4: begin
          if (is_data) begin
            upm_d           = internal_bus[0];
            aeoi_d          = internal_bus[1];
            buffered_mode_d = internal_bus[3:2];
            sfnm_d          = internal_bus[4];
            state_d         = StReady;
          end
        end
        StReady: begin
          if (is_data) begin
            imr_d = internal_bus;
          end
          if (is_ocw2) begin
            ocw2_cmd_d   = {internal_bus[7:5], internal_bus[2:0]};
            ocw2_valid_d = 1'b1;
            // R,SL,EOI = 100 enters rotate-in-AEOI mode, 000 leaves it.
            if (internal_bus[7:5] == 3'b100) begin
              rotate_aeoi_d = 1'b1;
            end else if (internal_bus[7:5] == 3'b000) begin
              rotate_aeoi_d = 1'b0;
            end
          end
          if (is_ocw3) begin
            if (internal_bus[1]) begin
              read_isr_d = internal_bus[0];
            end
            if (internal_bus[6]) begin
              special_mask_d = internal_bus[5];
            end
            poll_req_d = internal_bus[2];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      state_q          <= StIdle;
      we_q             <= 1'b0;
      ic4_q            <= 1'b0;
      edge_level_q     <= 1'b0;
      single_mode_q    <= 1'b0;
      vector_base_q    <= 5'h00;
      cascade_config_q <= 8'h00;
      aeoi_q           <= 1'b0;
      buffered_mode_q  <= 2'b00;
      sfnm_q           <= 1'b0;
      upm_q            <= 1'b0;
      imr_q            <= 8'h00;
      ocw2_valid_q     <= 1'b0;
      ocw2_cmd_q       <= 6'h00;
      rotate_aeoi_q    <= 1'b0;
      read_isr_q       <= 1'b0;
      special_mask_q   <= 1'b0;
      poll_req_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      we_q             <= write_enable;
      ic4_q            <= ic4_d;
      edge_level_q     <= edge_level_d;
      single_mode_q    <= single_mode_d;
      vector_base_q    <= vector_base_d;
      cascade_config_q <= cascade_config_d;
      aeoi_q           <= aeoi_d;
      buffered_mode_q  <= buffered_mode_d;
      sfnm_q           <= sfnm_d;
      upm_q            <= upm_d;
      imr_q            <= imr_d;
      ocw2_valid_q     <= ocw2_valid_d;
      ocw2_cmd_q       <= ocw2_cmd_d;
      rotate_aeoi_q    <= rotate_aeoi_d;
      read_isr_q       <= read_isr_d;
      special_mask_q   <= special_mask_d;
      poll_req_q       <= poll_req_d;
    end
  end

  always_comb begin
    init_done      = (state_q == StReady);
    edge_level     = edge_level_q;
    single_mode    = single_mode_q;
    vector_base    = vector_base_q;
    cascade_config = cascade_config_q;
    aeoi           = aeoi_q;
    buffered_mode  = buffered_mode_q;
    sfnm           = sfnm_q;
    upm            = upm_q;
    imr            = imr_q;
    ocw2_valid     = ocw2_valid_q;
    ocw2_cmd       = ocw2_cmd_q;
    rotate_aeoi    = rotate_aeoi_q;
    read_isr       = read_isr_q;
    special_mask   = special_mask_q;
    poll_req       = poll_req_q;
  end

endmodule

// File: tb/tb_init_command_sequencer.sv
// Bench for init_command_sequencer: table of write events with expected output snapshots,
// routed through a scoreboard queue, plus hand-written reset and idle sequences.
module tb_init_command_sequencer;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic       write_enable;
  logic       A0;
  logic [7:0] internal_bus;
  logic       init_done, edge_level, single_mode, aeoi, sfnm, upm;
  logic       ocw2_valid, rotate_aeoi, read_isr, special_mask, poll_req;
  logic [4:0] vector_base;
  logic [7:0] cascade_config, imr;
  logic [1:0] buffered_mode;
  logic [5:0] ocw2_cmd;

  init_command_sequencer dut (
    .clk            (clk),
    .reset_bar      (reset_bar),
    .write_enable   (write_enable),
    .A0             (A0),
    .internal_bus   (internal_bus),
    .init_done      (init_done),
    .edge_level     (edge_level),
    .single_mode    (single_mode),
    .vector_base    (vector_base),
    .cascade_config (cascade_config),
    .aeoi           (aeoi),
    .buffered_mode  (buffered_mode),
    .sfnm           (sfnm),
    .upm            (upm),
    .imr            (imr),
    .ocw2_valid     (ocw2_valid),
    .ocw2_cmd       (ocw2_cmd),
    .rotate_aeoi    (rotate_aeoi),
    .read_isr       (read_isr),
    .special_mask   (special_mask),
    .poll_req       (poll_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       init_done;
    logic       edge_level;
    logic       single_mode;
    logic [4:0] vb;
    logic [7:0] cc;
    logic       aeoi;
    logic [1:0] bufm;
    logic       sfnm;
    logic       upm;
    logic [7:0] imr;
    logic       v;
    logic [5:0] cmd;
    logic       rot;
    logic       risr;
    logic       smm;
    logic       poll;
  } out_t;

  typedef struct {
    string name;
    logic  a0;
    logic [7:0] data;
    int    hold;
    out_t  exp;
  } vec_t;

  vec_t  tbl[$];
  out_t  sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic out_t mk(input logic i, input logic el, input logic sg, input logic [4:0] vb,
                              input logic [7:0] cc, input logic ae, input logic [1:0] bm,
                              input logic sf, input logic up, input logic [7:0] im,
                              input logic v, input logic [5:0] cmd, input logic rot,
                              input logic ri, input logic sm, input logic pl);
    out_t o;
    o.init_done = i;  o.edge_level = el; o.single_mode = sg; o.vb = vb; o.cc = cc;
    o.aeoi = ae; o.bufm = bm; o.sfnm = sf; o.upm = up; o.imr = im; o.v = v; o.cmd = cmd;
    o.rot = rot; o.risr = ri; o.smm = sm; o.poll = pl;
    return o;
  endfunction

  function automatic out_t sample();
    return mk(init_done, edge_level, single_mode, vector_base, cascade_config, aeoi,
              buffered_mode, sfnm, upm, imr, ocw2_valid, ocw2_cmd, rotate_aeoi, read_isr,
              special_mask, poll_req);
  endfunction

  function automatic out_t quiet(input out_t e);
    out_t q = e;
    q.v    = 1'b0;
    q.poll = 1'b0;
    return q;
  endfunction

  task automatic add(input string name, input logic a0, input logic [7:0] data, input int hold,
                     input out_t exp);
    vec_t r;
    r.name = name; r.a0 = a0; r.data = data; r.hold = hold; r.exp = exp;
    tbl.push_back(r);
  endtask

  task automatic check(input string name);
    out_t got, want;
    got = sample();
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      want = sb_q.pop_front();
      if (got !== want) begin
        n_err++;
        $display("FAIL %s: got %h want %h", name, got, want);
      end
    end
  endtask

  // Drive one write held for `hold` cycles, then check the steady state after release.
  task automatic apply(input string name, input logic a0, input logic [7:0] data, input int hold,
                       input out_t exp);
    @(negedge clk);
    write_enable = 1'b1; A0 = a0; internal_bus = data;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    check(name);
    for (int k = 1; k < hold; k++) begin
      sb_q.push_back(quiet(exp));
      @(posedge clk); #1;
      check({name, "_held"});
    end
    @(negedge clk);
    write_enable = 1'b0;
    sb_q.push_back(quiet(exp));
    @(posedge clk); #1;
    check({name, "_after"});
  endtask

  out_t zero;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zero = '0;
    reset_bar = 1'b0; write_enable = 1'b0; A0 = 1'b0; internal_bus = 8'h00;

    //   init el   sg   vb     cc     ae   bm     sf   up   imr    v    cmd        rot  ri   sm   pl
    add("icw1_sngl", 1'b0, 8'h12, 1,
        mk(1'b0,1'b0,1'b1,5'h00,8'h00,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("icw2_ready", 1'b1, 8'h40, 1,
        mk(1'b1,1'b0,1'b1,5'h08,8'h00,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("icw1_casc", 1'b0, 8'h11, 1,
        mk(1'b0,1'b0,1'b0,5'h08,8'h00,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("icw2_casc", 1'b1, 8'h20, 1,
        mk(1'b0,1'b0,1'b0,5'h04,8'h00,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("ocw2_in_icw3", 1'b0, 8'h20, 1,
        mk(1'b0,1'b0,1'b0,5'h04,8'h00,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("icw3", 1'b1, 8'h04, 1,
        mk(1'b0,1'b0,1'b0,5'h04,8'h04,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("ocw3_in_icw4", 1'b0, 8'h6B, 1,
        mk(1'b0,1'b0,1'b0,5'h04,8'h04,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("icw4", 1'b1, 8'h03, 1,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'h00,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("ocw1_held", 1'b1, 8'hA5, 5,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hA5,1'b0,6'b000000,1'b0,1'b0,1'b0,1'b0));
    add("ocw2_60_held", 1'b0, 8'h60, 3,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hA5,1'b1,6'b011000,1'b0,1'b0,1'b0,1'b0));
    add("ocw3_6b", 1'b0, 8'h6B, 1,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hA5,1'b0,6'b011000,1'b0,1'b1,1'b1,1'b0));
    add("ocw3_poll", 1'b0, 8'h0C, 2,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hA5,1'b0,6'b011000,1'b0,1'b1,1'b1,1'b1));
    add("ocw2_rot_set", 1'b0, 8'h80, 1,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hA5,1'b1,6'b100000,1'b1,1'b1,1'b1,1'b0));
    add("ocw2_eoi_keep", 1'b0, 8'h20, 1,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hA5,1'b1,6'b001000,1'b1,1'b1,1'b1,1'b0));
    add("ocw2_rot_clr", 1'b0, 8'h00, 1,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hA5,1'b1,6'b000000,1'b0,1'b1,1'b1,1'b0));
    add("ocw2_rot_set2", 1'b0, 8'h80, 1,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hA5,1'b1,6'b100000,1'b1,1'b1,1'b1,1'b0));
    add("ocw1_ff", 1'b1, 8'hFF, 1,
        mk(1'b1,1'b0,1'b0,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'hFF,1'b0,6'b100000,1'b1,1'b1,1'b1,1'b0));
    add("reinit_13", 1'b0, 8'h13, 1,
        mk(1'b0,1'b0,1'b1,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'h00,1'b0,6'b100000,1'b0,1'b0,1'b0,1'b0));
    add("ocw2_in_icw2", 1'b0, 8'hA0, 1,
        mk(1'b0,1'b0,1'b1,5'h04,8'h04,1'b1,2'b00,1'b0,1'b1,8'h00,1'b0,6'b100000,1'b0,1'b0,1'b0,1'b0));
    add("icw1_1a_clr", 1'b0, 8'h1A, 1,
        mk(1'b0,1'b1,1'b1,5'h04,8'h04,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b100000,1'b0,1'b0,1'b0,1'b0));
    add("icw2_48", 1'b1, 8'h48, 1,
        mk(1'b1,1'b1,1'b1,5'h09,8'h04,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b100000,1'b0,1'b0,1'b0,1'b0));
    add("icw1_1b", 1'b0, 8'h1B, 1,
        mk(1'b0,1'b1,1'b1,5'h09,8'h04,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b100000,1'b0,1'b0,1'b0,1'b0));
    add("icw2_to_icw4", 1'b1, 8'h50, 1,
        mk(1'b0,1'b1,1'b1,5'h0A,8'h04,1'b0,2'b00,1'b0,1'b0,8'h00,1'b0,6'b100000,1'b0,1'b0,1'b0,1'b0));
    add("icw4_1c", 1'b1, 8'h1C, 1,
        mk(1'b1,1'b1,1'b1,5'h0A,8'h04,1'b0,2'b11,1'b1,1'b0,8'h00,1'b0,6'b100000,1'b0,1'b0,1'b0,1'b0));
    add("icw1_keep_icw4", 1'b0, 8'h11, 1,
        mk(1'b0,1'b0,1'b0,5'h0A,8'h04,1'b0,2'b11,1'b1,1'b0,8'h00,1'b0,6'b100000,1'b0,1'b0,1'b0,1'b0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(zero);
    check("reset_state");
    @(negedge clk);
    reset_bar = 1'b1;

    foreach (tbl[i]) apply(tbl[i].name, tbl[i].a0, tbl[i].data, tbl[i].hold, tbl[i].exp);

    // Reset mid-initialisation coincides with an A0=1 event: reset wins.
    @(negedge clk);
    reset_bar = 1'b0; write_enable = 1'b1; A0 = 1'b1; internal_bus = 8'h48;
    sb_q.push_back(zero);
    @(posedge clk); #1;
    check("reset_vs_event");
    @(negedge clk);
    reset_bar = 1'b1; write_enable = 1'b0;
    sb_q.push_back(zero);
    @(posedge clk); #1;
    check("reset_release");

    // In IDLE every non-ICW1 event is ignored.
    apply("idle_data", 1'b1, 8'h48, 1, zero);
    apply("idle_ocw2", 1'b0, 8'h80, 1, zero);
    apply("idle_ocw3", 1'b0, 8'h0C, 1, zero);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
